// File: rtl/pc_gen_ras.sv
// pc_gen_ras: next-PC generator with a circular return-address stack (RAS).
// Define PC_GEN_RAS_STATS_EN to add RAS hit/miss prediction counters.
module pc_gen_ras #(
   parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic [1:0]  npc_op_i,
   input  logic [25:0] imm_i,
   input  logic [31:0] rf_i,
   input  logic        call_i,
   input  logic        ret_i,
   output logic [31:0] pc_o,
   output logic [31:0] npc_o,
   output logic [31:0] ras_top_o,
   output logic        ras_valid_o
`ifdef PC_GEN_RAS_STATS_EN
   ,
   output logic [31:0] ras_hit_cnt_o,
   output logic [31:0] ras_miss_cnt_o
`endif
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [1:0] OP_NORMAL = 2'b00;
   localparam logic [1:0] OP_BRANCH = 2'b01;
   localparam logic [1:0] OP_JUMP   = 2'b10;
   localparam logic [1:0] OP_RF     = 2'b11;

   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      ras_mem_q [RAS_DEPTH];

   logic [31:0]      pc_plus4, pc_plus8, br_off, npc_c;
   logic [PTR_W-1:0] top_idx;
   logic             ras_empty, ras_full;
   logic             advance, ras_en, push, pop_req, pop;
   logic             ras_we;
   logic [PTR_W-1:0] ras_widx;
   logic [31:0]      ras_wdata;

   assign pc_plus4  = pc_q + 32'd4;
   assign pc_plus8  = pc_q + 32'd8;
   assign br_off    = {{14{imm_i[15]}}, imm_i[15:0], 2'b00};
   assign top_idx   = ptr_q - PTR_W'(1);
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

   // Redirect overrides stall; RAS only moves on a normally advancing cycle.
   assign advance = redirect_i | ~stall_i;
   assign ras_en  = ~stall_i & ~redirect_i;
   assign push    = ras_en & call_i;
   assign pop_req = ras_en & ret_i & (npc_op_i == OP_RF);
   assign pop     = pop_req & ~ras_empty;

   // Next-PC select
   always_comb begin
      npc_c = pc_plus4;
      if (redirect_i) begin
         npc_c = redirect_pc_i;
      end else begin
         case (npc_op_i)
            OP_NORMAL: npc_c = pc_plus4;
            OP_BRANCH: npc_c = pc_plus4 + br_off;
            OP_JUMP:   npc_c = {pc_plus4[31:28], imm_i, 2'b00};
            OP_RF:     npc_c = rf_i & 32'hFFFF_FFFC;
            default:   npc_c = pc_plus4;
         endcase
      end
   end

   assign pc_d = advance ? npc_c : pc_q;

   // RAS pointer/count update; a push+pop on a live stack rewrites the top in place.
   always_comb begin
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      ras_we    = 1'b0;
      ras_widx  = ptr_q;
      ras_wdata = pc_plus8;
      if (push && pop) begin
         ras_we   = 1'b1;
         ras_widx = top_idx;
      end else if (push) begin
         ras_we   = 1'b1;
         ras_widx = ptr_q;
         ptr_d    = ptr_q + PTR_W'(1);
         cnt_d    = ras_full ? cnt_q : cnt_q + CNT_W'(1);
      end else if (pop) begin
         ptr_d = ptr_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage is left unreset; it is masked while the count is zero.
   always_ff @(posedge clk) begin
      if (ras_we) begin
         ras_mem_q[ras_widx] <= ras_wdata;
      end
   end

   assign pc_o        = pc_q;
   assign npc_o       = npc_c;
   assign ras_valid_o = ~ras_empty;
   assign ras_top_o   = ras_empty ? 32'd0 : ras_mem_q[top_idx];

`ifdef PC_GEN_RAS_STATS_EN
   logic [31:0] hit_q, hit_d, miss_q, miss_d;

   // Score every qualifying return against the predicted target (empty counts as miss).
   always_comb begin
      hit_d  = hit_q;
      miss_d = miss_q;
      if (pop_req) begin
         if (!ras_empty && (rf_i[31:2] == ras_top_o[31:2])) begin
            hit_d = hit_q + 32'd1;
         end else begin
            miss_d = miss_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         hit_q  <= hit_d;
         miss_q <= miss_d;
      end
   end

   assign ras_hit_cnt_o  = hit_q;
   assign ras_miss_cnt_o = miss_q;
`endif

endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: directed scenarios plus random stimulus against a queue-based
// reference model of the PC generator and return-address stack.
module tb_pc_gen_ras;

   localparam int unsigned DEPTH  = 8;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst, stall_i, redirect_i, call_i, ret_i;
   logic [31:0] redirect_pc_i, rf_i;
   logic [1:0]  npc_op_i;
   logic [25:0] imm_i;
   logic [31:0] pc_o, npc_o, ras_top_o;
   logic        ras_valid_o;
`ifdef PC_GEN_RAS_STATS_EN
   logic [31:0] ras_hit_cnt_o, ras_miss_cnt_o;
`endif

   pc_gen_ras #(.RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .npc_op_i      (npc_op_i),
      .imm_i         (imm_i),
      .rf_i          (rf_i),
      .call_i        (call_i),
      .ret_i         (ret_i),
      .pc_o          (pc_o),
      .npc_o         (npc_o),
      .ras_top_o     (ras_top_o),
      .ras_valid_o   (ras_valid_o)
`ifdef PC_GEN_RAS_STATS_EN
      ,
      .ras_hit_cnt_o (ras_hit_cnt_o),
      .ras_miss_cnt_o(ras_miss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic [31:0] m_hit, m_miss;
   bit          m_known = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_top();
      return (m_ras.size() > 0) ? m_ras[$] : 32'd0;
   endfunction

   function automatic logic [31:0] ref_npc();
      logic [31:0] seq;
      int          off;
      seq = m_pc + 32'd4;
      if (redirect_i) return redirect_pc_i;
      case (npc_op_i)
         2'b00:   return seq;
         2'b01: begin
            off = int'($signed(imm_i[15:0])) * 4;
            return seq + 32'(off);
         end
         2'b10:   return {seq[31:28], imm_i, 2'b00};
         default: return {rf_i[31:2], 2'b00};
      endcase
   endfunction

   task automatic idle();
      rst = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
      npc_op_i = 2'b00; imm_i = '0; rf_i = '0; call_i = 0; ret_i = 0;
   endtask

   // One clock: check npc before the edge, advance the model, check state after.
   task automatic cycle(input string tag);
      logic [31:0] npc, ret_addr;
      bit          live, do_push, do_pop;
      #1;
      npc = ref_npc();
      if (m_known) check({tag, "_npc"}, npc_o, npc);
      @(posedge clk);
      if (rst) begin
         m_pc = RST_PC; m_ras.delete(); m_hit = 0; m_miss = 0; m_known = 1;
      end else begin
         ret_addr = m_pc + 32'd8;
         live     = !stall_i && !redirect_i;
         do_push  = live && call_i;
         do_pop   = live && ret_i && (npc_op_i == 2'b11);
         if (do_pop) begin
            if (m_ras.size() > 0 && rf_i[31:2] == m_top() >> 2) m_hit++;
            else m_miss++;
         end
         if (do_push && do_pop && m_ras.size() > 0) begin
            m_ras[m_ras.size()-1] = ret_addr;
         end else if (do_push) begin
            if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(ret_addr);
         end else if (do_pop && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
         end
         if (redirect_i || !stall_i) m_pc = npc;
      end
      #1;
      check({tag, "_pc"}, pc_o, m_pc);
      check({tag, "_top"}, ras_top_o, m_top());
      check({tag, "_valid"}, 32'(ras_valid_o), 32'(m_ras.size() > 0));
`ifdef PC_GEN_RAS_STATS_EN
      check({tag, "_hit"}, ras_hit_cnt_o, m_hit);
      check({tag, "_miss"}, ras_miss_cnt_o, m_miss);
`endif
   endtask

   task automatic do_reset();
      idle(); rst = 1; cycle("rst"); rst = 0;
   endtask

   initial begin
      idle();
      @(posedge clk); #1;

      // Reset state and sequential fetch
      do_reset();
      check("rst_pc", pc_o, RST_PC);
      check("rst_valid", 32'(ras_valid_o), 32'd0);
      check("rst_top", ras_top_o, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         cycle("seq");
         check("seq_pc_const", pc_o, RST_PC + 32'(4 * i));
      end

      // Branch and jump targets from a fixed PC (stalled so PC holds)
      redirect_i = 1; redirect_pc_i = 32'h0040_0010; cycle("redir"); idle();
      stall_i = 1; npc_op_i = 2'b01; imm_i = 26'h000_FFFC; #1;
      check("br_npc_const", npc_o, 32'h0040_0004);
      cycle("br_stall");
      npc_op_i = 2'b10; imm_i = 26'h010_0000; #1;
      check("jmp_npc_const", npc_o, 32'h0040_0000);
      cycle("jmp_stall"); idle();

      // Call, stall, return with a matching target
      do_reset();
      redirect_i = 1; redirect_pc_i = 32'h0000_1000; cycle("to1000"); idle();
      call_i = 1; cycle("call");
      check("call_top_const", ras_top_o, 32'h0000_1008);
      idle(); stall_i = 1; cycle("stall");
      check("stall_top_const", ras_top_o, 32'h0000_1008);
      idle(); ret_i = 1; npc_op_i = 2'b11; rf_i = 32'h0000_1008; cycle("ret");
      check("ret_valid_const", 32'(ras_valid_o), 32'd0);
`ifdef PC_GEN_RAS_STATS_EN
      check("ret_hit_const", ras_hit_cnt_o, 32'd1);
`endif
      idle();

      // Overflow: DEPTH+2 calls, DEPTH pops newest-first, then a pop on empty
      for (int i = 0; i < DEPTH + 2; i++) begin call_i = 1; cycle("ovf_call"); end
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         ret_i = 1; npc_op_i = 2'b11; rf_i = $urandom; cycle("ovf_pop");
      end
      check("ovf_empty_const", 32'(ras_valid_o), 32'd0);
      ret_i = 1; npc_op_i = 2'b11; rf_i = 32'h1234_5678; cycle("pop_empty");
      idle();

      // Redirect beats stall and suppresses the call push
      call_i = 1; cycle("pre_call"); idle();
      redirect_i = 1; stall_i = 1; call_i = 1; redirect_pc_i = 32'hBFC0_0380;
      cycle("redir_stall");
      check("redir_pc_const", pc_o, 32'hBFC0_0380);
      idle();

      // Reset with live entries
      for (int i = 0; i < 3; i++) begin call_i = 1; cycle("live_call"); end
      idle(); rst = 1; stall_i = 1; redirect_i = 1; cycle("mid_rst");
      check("mid_rst_pc_const", pc_o, RST_PC);
      check("mid_rst_valid_const", 32'(ras_valid_o), 32'd0);
      idle();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 199) == 0);
         stall_i       = ($urandom_range(0, 3) == 0);
         redirect_i    = ($urandom_range(0, 15) == 0);
         redirect_pc_i = $urandom;
         npc_op_i      = 2'($urandom_range(0, 3));
         imm_i         = 26'($urandom);
         call_i        = ($urandom_range(0, 3) == 0);
         ret_i         = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 1 && m_ras.size() > 0)
            rf_i = m_top() | 32'($urandom_range(0, 3));
         else
            rf_i = $urandom;
         cycle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen_ras.md
PC_GEN_RAS -- requirements
Module: pc_gen_ras

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, PC value loaded on reset.
REQ-002 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries (power of two, 2..64).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall_i, input, 1, hold PC and RAS this cycle.
REQ-006 SHALL have port redirect_i, input, 1, exception/flush redirect request.
REQ-007 SHALL have port redirect_pc_i, input, 32, redirect target.
REQ-008 SHALL have port npc_op_i, input, 2, next-PC select: 00 NORMAL, 01 BRANCH, 10 JUMP, 11 RF.
REQ-009 SHALL have port imm_i, input, 26, branch offset in bits [15:0] or jump index in bits [25:0].
REQ-010 SHALL have port rf_i, input, 32, register-file jump target.
REQ-011 SHALL have port call_i, input, 1, current instruction is a link call (JAL/JALR).
REQ-012 SHALL have port ret_i, input, 1, current instruction is a return (JR $ra).
REQ-013 SHALL have port pc_o, output, 32, registered current PC.
REQ-014 SHALL have port npc_o, output, 32, combinational next PC.
REQ-015 SHALL have port ras_top_o, output, 32, top RAS entry (predicted return target); 0 when empty.
REQ-016 SHALL have port ras_valid_o, output, 1, RAS non-empty.

Function
REQ-017 SHALL compute npc_o as: redirect_i=1 -> redirect_pc_i; otherwise NORMAL -> pc_o+4; BRANCH -> pc_o+4+(sign-extended imm_i[15:0] shifted left 2); JUMP -> {(pc_o+4)[31:28], imm_i, 2'b00}; RF -> {rf_i[31:2], 2'b00}; all arithmetic modulo 2^32.
REQ-018 SHALL define "advance" as redirect_i | !stall_i; pc_o loads npc_o on every advance edge and holds otherwise (redirect overrides stall).
REQ-019 SHALL push pc_o+8 onto the RAS when call_i & !stall_i & !redirect_i.
REQ-020 SHALL pop the RAS when ret_i & npc_op_i==RF & !stall_i & !redirect_i and RAS is non-empty; a pop when empty is a no-op.
REQ-021 SHALL, on simultaneous push and pop, replace the top entry with pc_o+8 and leave the count unchanged (empty case: plain push).
REQ-022 SHALL, on push when full, overwrite the oldest entry circularly, the count saturating at RAS_DEPTH.
REQ-023 SHALL keep RAS pointer and count unchanged when redirect_i or stall_i is asserted.
REQ-024 SHALL drive ras_top_o and ras_valid_o directly from registered state (no combinational path from inputs).

Reset
REQ-025 SHALL, on rst at a clk edge, set pc_o=RESET_PC, RAS count=0, pointer=0, ras_valid_o=0, ras_top_o=0; rst has priority over redirect_i and stall_i.
REQ-026 SHALL leave RAS entry storage contents unreset (invisible while count=0).

Configuration
REQ-027 SHALL, when macro PC_GEN_RAS_STATS_EN is defined, add outputs ras_hit_cnt_o (32) and ras_miss_cnt_o (32), reset to 0, wrapping at 2^32.
REQ-028 SHALL, with the macro, on each qualifying pop (REQ-020 conditions, including empty) increment hit if RAS non-empty and rf_i[31:2]==ras_top_o[31:2], else increment miss.
REQ-029 SHALL, without the macro, omit both counter ports and logic; all other behaviour identical.

Verification
REQ-030 Reset then 3 advancing NORMAL cycles -> pc_o BFC00000, BFC00004, BFC00008, BFC0000C.
REQ-031 pc_o=0x00400010, BRANCH imm[15:0]=0xFFFC -> npc_o=0x00400004; JUMP imm=0x0100000 -> npc_o=0x00400000.
REQ-032 call at pc 0x1000, stall one cycle, ret with rf_i=0x1008 -> ras_top_o=0x1008 after call, unchanged during stall, ras_valid_o=0 after ret, hit count=1.
REQ-033 RAS_DEPTH+2 calls -> count=RAS_DEPTH, RAS_DEPTH pops return newest-first, further pop no-op, miss counted.
REQ-034 redirect_i with stall_i and call_i asserted, redirect_pc_i=0xBFC00380 -> pc_o=0xBFC00380 next cycle, RAS unchanged.
REQ-035 rst asserted mid-sequence with 3 entries live -> pc_o=RESET_PC, ras_valid_o=0 next cycle.
